sort_mem_arbiter: RTL and testbench

Two-requester arbiter sharing the single sorter Memory port between requester 0 (host loader/unloader) and requester 1 (SelectionSorter datapath/controller). It drives readMem/writeMem/addrBus/inBus, waits for rdyMem, then returns one rdy pulse plus read data to the granted requester. A per-transaction timeout counter aborts hung accesses with an error flag.

---
 rtl/sort_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sort_mem_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sort_mem_arbiter.sv
`timescale 1ns/1ps
// sort_mem_arbiter
// ----------------
// This block shares the single sorter memory port between two requesters.
// Requester 0 is the host loader/unloader. Requester 1 is the SelectionSorter
// datapath/controller. A granted access runs for one transaction through
// IDLE -> BUSY -> RESP and ends with a one-cycle rdy pulse to the owner.
//
// Handshake
//   Each requester raises read or write as a level and holds it, with its
//   address and write data stable, until its rdy pulse. The arbiter samples
//   requests only in IDLE. In BUSY it holds exactly one memory strobe high and
//   waits for rdyMem. If rdyMem does not arrive within TIMEOUT BUSY cycles, the
//   access is aborted and err is raised together with rdy. rdata and err are
//   meaningful only in the cycle the owner's rdy is high.
//
// Optional feature
//   `ARB_RR_EN: round-robin arbitration when both requesters are active. When
//   this macro is not defined, requester 0 wins every tie.
//
// Ports
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   r0_* / r1_*         read/write request, address, and write data per requester
//   r0_rdy / r1_rdy     completion pulses
//   rdata, err, owner   response data, timeout flag, and the latched requester
//   readMem, writeMem   memory strobes (registered)
//   addrBus, inBus      memory address and write data (registered)
//   rdyMem, outBus      memory completion and read data
//   state_dbg           current FSM state (IDLE=0, BUSY=1, RESP=2)
module sort_mem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_read,
    input  logic          r0_write,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_rdy,
    input  logic          r1_read,
    input  logic          r1_write,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_rdy,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          owner,
    output logic          readMem,
    output logic          writeMem,
    output logic [AW-1:0] addrBus,
    output logic [DW-1:0] inBus,
    input  logic          rdyMem,
    input  logic [DW-1:0] outBus,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t        state;
    logic [7:0]    cnt;
    logic [7:0]    cnt_next;
    logic          r0_act;
    logic          r1_act;
    logic          grant_r1;
    logic          sel_write;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

`ifdef ARB_RR_EN
    // This bit names the requester that wins the next tie.
    // It is set to the requester that was not granted last.
    logic rr_ptr;
`endif

    assign r0_act   = r0_read | r0_write;
    assign r1_act   = r1_read | r1_write;
    assign cnt_next = cnt + 8'd1;
    assign state_dbg = state;

`ifdef ARB_RR_EN
    assign grant_r1 = r1_act & (~r0_act | rr_ptr);
`else
    assign grant_r1 = r1_act & ~r0_act;
`endif

    // Only the winner's inputs reach the latches.
    // If read and write are both high, write takes precedence.
    assign sel_write = grant_r1 ? r1_write : r0_write;
    assign sel_addr  = grant_r1 ? r1_addr  : r0_addr;
    assign sel_wdata = grant_r1 ? r1_wdata : r0_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            r0_rdy   <= 1'b0;
            r1_rdy   <= 1'b0;
            rdata    <= '0;
            err      <= 1'b0;
            owner    <= 1'b0;
            readMem  <= 1'b0;
            writeMem <= 1'b0;
            addrBus  <= '0;
            inBus    <= '0;
`ifdef ARB_RR_EN
            rr_ptr   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    r0_rdy <= 1'b0;
                    r1_rdy <= 1'b0;
                    err    <= 1'b0;
                    if (r0_act || r1_act) begin
                        owner    <= grant_r1;
                        writeMem <= sel_write;
                        readMem  <= ~sel_write;
                        addrBus  <= sel_addr;
                        inBus    <= sel_wdata;
                        cnt      <= 8'd0;
                        state    <= BUSY;
`ifdef ARB_RR_EN
                        rr_ptr   <= ~grant_r1;
`endif
                    end
                end
                BUSY: begin
                    cnt <= cnt_next;
                    // rdyMem is checked first, so a completion in the final
                    // allowed cycle still counts as a successful access.
                    if (rdyMem) begin
                        if (readMem) rdata <= outBus;
                        err      <= 1'b0;
                        readMem  <= 1'b0;
                        writeMem <= 1'b0;
                        r0_rdy   <= ~owner;
                        r1_rdy   <= owner;
                        state    <= RESP;
                    end else if (cnt_next == TO_LIM) begin
                        err      <= 1'b1;
                        readMem  <= 1'b0;
                        writeMem <= 1'b0;
                        r0_rdy   <= ~owner;
                        r1_rdy   <= owner;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    r0_rdy <= 1'b0;
                    r1_rdy <= 1'b0;
                    err    <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_mem_arbiter.sv
`timescale 1ns/1ps
module tb_sort_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 15;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0_read, r0_write, r1_read, r1_write;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_rdy, r1_rdy, err, owner, readMem, writeMem, rdyMem;
    logic [DW-1:0] rdata, inBus, outBus;
    logic [AW-1:0] addrBus;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    sort_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .r0_read(r0_read), .r0_write(r0_write), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_rdy(r0_rdy),
        .r1_read(r1_read), .r1_write(r1_write), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_rdy(r1_rdy),
        .rdata(rdata), .err(err), .owner(owner),
        .readMem(readMem), .writeMem(writeMem), .addrBus(addrBus),
        .inBus(inBus), .rdyMem(rdyMem), .outBus(outBus),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          failures = 0;
    logic [17:0] exp_q[$];        // {owner, err, rdata}
    logic [17:0] e;
    logic        last_owner;
    logic [15:0] model_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // This task predicts the response of one transaction.
    // lat = 0 means the memory never answers.
    task automatic expect_txn(input logic own, input logic wr, input int lat, input logic [15:0] mem_data);
        logic e_err;
        e_err = !(lat >= 1 && lat <= TO);
        if (!wr && !e_err) model_rdata = mem_data;
        exp_q.push_back({own, e_err, model_rdata});
        last_owner = own;
    endtask

    // monitor
    always @(negedge clk) begin
        if (r0_rdy || r1_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rdy: got r0_rdy=%0b r1_rdy=%0b expected none", r0_rdy, r1_rdy);
            end else begin
                e = exp_q.pop_front();
                check("rdy_lines", {30'd0, r1_rdy, r0_rdy}, e[17] ? 32'd2 : 32'd1);
                check("owner", owner, e[17]);
                check("err", err, e[16]);
                check("rdata", rdata, e[15:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // This task acts as the memory side for one transaction. It answers lat
    // strobe cycles after the strobe starts, or never if lat = 0.
    task automatic serve(input int lat, input logic [15:0] mem_data, input logic exp_wr,
                         input logic [7:0] exp_addr, input logic [15:0] exp_wd, input string tag);
        int n;
        int waitc;
        int exp_n;
        waitc = 0;
        do begin
            @(posedge clk); #1;
            waitc++;
        end while (!(readMem || writeMem) && waitc < 10);
        if (!(readMem || writeMem)) begin
            checks++;
            failures++;
            $display("FAIL %s_start: got no strobe expected strobe within 10 cycles", tag);
            return;
        end
        check({tag, "_readMem"}, readMem, !exp_wr);
        check({tag, "_writeMem"}, writeMem, exp_wr);
        check({tag, "_addrBus"}, addrBus, exp_addr);
        if (exp_wr) check({tag, "_inBus"}, inBus, exp_wd);
        n = 0;
        while ((readMem || writeMem) && n < 300) begin
            n++;
            if (n == lat) begin
                rdyMem = 1'b1;
                outBus = mem_data;
            end
            @(posedge clk); #1;
            rdyMem = 1'b0;
            outBus = 16'hDEAD;
        end
        exp_n = (lat >= 1 && lat <= TO) ? lat : TO;
        check({tag, "_busy_cycles"}, n, exp_n);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic own;
        logic [15:0] d;
        int waitc;
        r0_read = 0; r0_write = 0; r0_addr = 0; r0_wdata = 0;
        r1_read = 0; r1_write = 0; r1_addr = 0; r1_wdata = 0;
        rdyMem = 0; outBus = 16'hDEAD;
        model_rdata = 16'h0000;
        last_owner = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_readMem", readMem, 0);
        check("rst_writeMem", writeMem, 0);
        check("rst_rdy", {r1_rdy, r0_rdy}, 0);
        check("rst_err", err, 0);
        check("rst_owner", owner, 0);
        check("rst_rdata", rdata, 0);
        check("rst_addrBus", addrBus, 0);
        check("rst_inBus", inBus, 0);
        check("rst_state", state_dbg, 0);
        rst = 1'b1;

        // Requester 1 reads 0x05; the memory answers after 2 cycles.
        expect_txn(1'b1, 1'b0, 2, 16'hBEEF);
        r1_read = 1; r1_addr = 8'h05;
        serve(2, 16'hBEEF, 1'b0, 8'h05, 16'h0, "t1");
        r1_read = 0;

        // Both requesters stay active for 4 transactions.
        r0_read = 1; r0_addr = 8'h20;
        r1_read = 1; r1_addr = 8'h30;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            own = ~last_owner;
`else
            own = 1'b0;
`endif
            d = 16'h1000 + 16'(k);
            expect_txn(own, 1'b0, 1, d);
            serve(1, d, 1'b0, own ? 8'h30 : 8'h20, 16'h0, "arb");
        end
        r0_read = 0; r1_read = 0;

        // Requester 0 writes with read also high; the write must win.
        expect_txn(1'b0, 1'b1, 3, 16'h0);
        r0_write = 1; r0_read = 1; r0_addr = 8'h10; r0_wdata = 16'h1234;
        serve(3, 16'hFFFF, 1'b1, 8'h10, 16'h1234, "t2");
        r0_write = 0; r0_read = 0;

        // The memory never answers, so the access times out.
        expect_txn(1'b0, 1'b0, 0, 16'h0);
        r0_read = 1; r0_addr = 8'h40;
        serve(0, 16'h0, 1'b0, 8'h40, 16'h0, "timeout");
        r0_read = 0;

        // rdyMem arrives in the last allowed cycle.
        expect_txn(1'b1, 1'b0, TO, 16'hCAFE);
        r1_read = 1; r1_addr = 8'h41;
        serve(TO, 16'hCAFE, 1'b0, 8'h41, 16'h0, "edge");
        r1_read = 0;

        // Reset is asserted while the access is in BUSY.
        r0_write = 1; r0_addr = 8'h50; r0_wdata = 16'h7777;
        waitc = 0;
        do begin
            @(posedge clk); #1;
            waitc++;
        end while (!writeMem && waitc < 10);
        check("midrst_strobe_before", writeMem, 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_writeMem", writeMem, 0);
        check("midrst_readMem", readMem, 0);
        check("midrst_state", state_dbg, 0);
        r0_write = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_rdata = 16'h0000;
        last_owner = 1'b1;

        // A request after reset is serviced normally.
        expect_txn(1'b1, 1'b0, 1, 16'h5A5A);
        r1_read = 1; r1_addr = 8'h60;
        serve(1, 16'h5A5A, 1'b0, 8'h60, 16'h0, "post_rst");
        r1_read = 0;

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

endmodule
